imem_load_ctrl: RTL

Boot and run controller for the single-cycle RV32 core. It owns the instruction RAM write port while the core is held. It accepts program words from a host over a valid/ready handshake and writes them to sequential word addresses. It then releases the core and sequences it through run, halt and single-step. It sits between the host/debug interface and the core top level: it drives the instruction RAM readWrite/address/dataIN and the core hold/enable.

---
 rtl/imem_load_ctrl_if.sv | 20 ++
 rtl/imem_load_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/imem_load_ctrl_if.sv
// imem_load_ctrl_if: host word handshake plus instruction RAM write port
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    modport master (
        input  host_valid, host_data,
        output host_ready, ram_we, ram_addr, ram_wdata
    );
    modport slave (
        output host_valid, host_data,
        input  host_ready, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: loads program words into instruction RAM, then sequences core run/halt/step
module imem_load_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    imem_load_ctrl_if.master  bus,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              run_start,
    input  logic              halt_req,
    input  logic              step_req,
    output logic              core_hold,
    output logic              core_en,
    output logic              load_done,
    output logic [2:0]        state,
    output logic [31:0]       cyc_cnt
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, HALT = 3'd3, STEP = 3'd4} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
    state_t            cur, nxt;
    logic [ADDR_W:0]   cnt, len, eff_len;
    logic              xfer, last_wr, enter_load;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    assign eff_len        = (load_len == '0 || load_len > FULL) ? FULL : load_len;
    assign bus.host_ready = cur == LOAD && cnt < len;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign state          = cur;
    assign xfer           = bus.host_valid && bus.host_ready;
    // the final write pulse is on the bus while cnt has already reached len
    assign last_wr        = ram_we_q && cnt == len;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= IDLE;
        else      cur <= nxt;
    end
    always_comb begin
        nxt        = cur;
        enter_load = 1'b0;
        case (cur)
            IDLE:    nxt = load_start ? LOAD : (run_start && load_done) ? RUN : IDLE;
            LOAD:    nxt = (halt_req || last_wr) ? IDLE : LOAD;
            RUN:     nxt = halt_req ? HALT : RUN;
            HALT:    nxt = halt_req ? HALT : load_start ? LOAD : run_start ? RUN : step_req ? STEP : HALT;
            STEP:    nxt = HALT;
            default: nxt = IDLE;
        endcase
        enter_load = nxt == LOAD && cur != LOAD;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cnt         <= '0;
            len         <= '0;
            load_done   <= 1'b0;
            core_hold   <= 1'b1;
            core_en     <= 1'b0;
            cyc_cnt     <= '0;
        end else begin
            ram_we_q <= xfer;
            if (xfer) begin
                ram_addr_q  <= cnt[ADDR_W-1:0];
                ram_wdata_q <= bus.host_data;
            end
            cnt       <= enter_load ? '0 : cnt + (ADDR_W + 1)'(xfer);
            len       <= enter_load ? eff_len : len;
            load_done <= enter_load ? 1'b0 : (cur == LOAD && !halt_req && last_wr) ? 1'b1 : load_done;
            core_hold <= nxt == IDLE || nxt == LOAD;
            core_en   <= nxt == RUN || nxt == STEP;
            cyc_cnt   <= enter_load ? '0 : cyc_cnt + 32'(core_en);
        end
    end
endmodule
